schiebe_einheit: RTL
====================

Name: schiebe_einheit

Overview:
- Registered, valid/ready-handshaked shift/rotate execution stage of the ALU. Sits directly downstream of the combinational cyclic rotator.
- Stage 1 registers the rotated operand and the shift metadata. Stage 2 masks and sign-fills the rotated value, turning rotates into logical or arithmetic shifts, and produces the carry-out and zero flags.
- Result goes to ALU writeback.

Parameters:
- BREITE, 32, operand width in bits.
- LOG2BREITE, 5, width of Stellen; always log2(BREITE).

Ports:
- Takt, input, 1, single clock; all state updates on rising edge.
- Reset, input, 1, synchronous, active-high.
- EingabeGueltig, input, 1, upstream presents a valid operation.
- EingabeBereit, output, 1, block accepts an operation this cycle.
- Zahl, input, BREITE, operand.
- Stellen, input, LOG2BREITE, shift amount, 0..BREITE-1.
- Operation, input, 3, opcode: 000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA; 101-111 pass-through.
- AusgabeGueltig, output, 1, Ergebnis/flags valid.
- AusgabeBereit, input, 1, downstream accepts the result.
- Ergebnis, output, BREITE, shifted/rotated result.
- Uebertrag, output, 1, last bit shifted out.
- Null, output, 1, Ergebnis == 0.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high, sampled on the rising edge of Takt.
- Transfers:
  - Input transfer when EingabeGueltig && EingabeBereit at a rising edge.
  - Output transfer when AusgabeGueltig && AusgabeBereit.
- Pipeline: two stages, each with its own valid bit (V1, V2).
  - Stage 2 loads when !V2 or output transfer.
  - Stage 1 loads when !V1 or stage 1 advances to stage 2.
  - EingabeBereit = !Reset && (!V1 || stage-1-advances). This is a combinational path from AusgabeBereit.
- Latency: result valid exactly 2 cycles after the input transfer, with no stall. Throughput is 1 op/cycle under continuous AusgabeBereit.
- Stage 1 computes and registers R = cyclic rotate of Zahl by Stellen.
  - Direction: right for ROR/SRL/SRA, left otherwise.
  - Also registers Operation, Stellen, sign bit Zahl[BREITE-1], and carry C.
- Carry C:
  - Stellen == 0 or pass-through opcode: C = 0.
  - Left ops: C = Zahl[BREITE-Stellen].
  - Right ops: C = Zahl[Stellen-1].
- Stage 2 result:
  - ROL/ROR: Ergebnis = R.
  - SLL: bits i < Stellen forced 0.
  - SRL: bits i >= BREITE-Stellen forced 0.
  - SRA: bits i >= BREITE-Stellen forced to the registered sign bit.
  - Pass-through: Ergebnis = Zahl unmodified.
  - Stellen == 0: Ergebnis = Zahl for every opcode.
- Null is computed from the final stage-2 value and registered with it.
- Output stability: while AusgabeGueltig && !AusgabeBereit, Ergebnis, Uebertrag and Null hold stable and no later op overtakes.
- Ordering: results leave strictly in acceptance order. No drops, no duplicates.
- Reset values: V1 = V2 = 0, AusgabeGueltig = 0, Ergebnis = 0, Uebertrag = 0, Null = 0, EingabeBereit = 0 while Reset is high.
- Reset mid-operation: flushes both stages; in-flight ops are discarded. EingabeBereit is high in the first cycle after Reset deasserts.
- Simultaneous output transfer and new input with both stages full: both stages shift in the same edge; the new op enters stage 1.
- Shift amount range: Stellen is unsigned. No masking beyond LOG2BREITE bits; shift amounts >= BREITE cannot be expressed.

Test Plan (BREITE=32):
- ROL Zahl=0x80000001, Stellen=4, AusgabeBereit=1 -> 2 cycles later Ergebnis=0x00000018, Uebertrag=0, Null=0.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF, Uebertrag=0. Then SRL 0xF0000000 by 4 -> 0x0F000000. Then SLL 0x00000001 by 31 -> 0x80000000, Uebertrag=0. Then SLL 0x00000002 by 31 -> 0x00000000, Null=1, Uebertrag=1.
- ROR 0x12345678 by 0 -> 0x12345678, Uebertrag=0. Opcode 111 on 0xDEADBEEF by 7 -> 0xDEADBEEF, Uebertrag=0.
- Backpressure: issue ops A, B, C back-to-back with AusgabeBereit=0.
  - Required: A held on output unchanged; EingabeBereit drops once B occupies stage 1; C waits.
  - Raise AusgabeBereit: A, B, C delivered on consecutive cycles in order, with correct values.
- Streaming: 16 random ops with EingabeGueltig=1 and AusgabeBereit=1 -> one result per cycle, each matching the reference model, latency 2.
- Reset asserted one cycle after accepting an op -> AusgabeGueltig stays 0 and outputs read 0. The next accepted op after reset yields its correct result 2 cycles later.

Source files
------------

// File: rtl/schiebe_einheit.sv
// rtl/schiebe_einheit.sv - two-stage valid/ready shift/rotate execution stage
//
// Stage 1 registers the cyclically rotated operand, the opcode, the effective
// shift amount, the operand sign bit and the carry-out.
// Stage 2 masks and sign-fills the rotated value so that rotates become
// logical or arithmetic shifts. It also registers the result and the zero flag.
//
// Ports:
//   Takt            clock, rising edge
//   Reset           synchronous, active-high
//   EingabeGueltig  upstream operation valid
//   EingabeBereit   operation accepted this cycle (combinational from AusgabeBereit)
//   Zahl            operand
//   Stellen         shift amount 0..BREITE-1
//   Operation       000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, others pass-through
//   AusgabeGueltig  Ergebnis/Uebertrag/Null valid
//   AusgabeBereit   downstream accepts the result
//   Ergebnis        shifted/rotated result
//   Uebertrag       last bit shifted out
//   Null            Ergebnis == 0

module schiebe_einheit #(
    parameter int BREITE     = 32,
    parameter int LOG2BREITE = 5
) (
    input  logic                  Takt,
    input  logic                  Reset,
    input  logic                  EingabeGueltig,
    output logic                  EingabeBereit,
    input  logic [BREITE-1:0]     Zahl,
    input  logic [LOG2BREITE-1:0] Stellen,
    input  logic [2:0]            Operation,
    output logic                  AusgabeGueltig,
    input  logic                  AusgabeBereit,
    output logic [BREITE-1:0]     Ergebnis,
    output logic                  Uebertrag,
    output logic                  Null
);

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    // Stage 1 state
    logic                  v1;
    logic [BREITE-1:0]     rot1;
    logic [2:0]            op1;
    logic [LOG2BREITE-1:0] amt1;
    logic                  sign1;
    logic                  carry1;

    // Stage 2 state is the output register set
    logic                  v2;

    // Handshake control
    logic load2;
    logic adv1;
    logic in_fire;

    assign load2          = !v2 || AusgabeBereit;
    assign adv1           = v1 && load2;
    assign EingabeBereit  = !Reset && (!v1 || adv1);
    assign in_fire        = EingabeGueltig && EingabeBereit;
    assign AusgabeGueltig = v2;

    // Stage 1 combinational: rotate and carry
    logic                  is_pass;
    logic                  is_right;
    logic [LOG2BREITE-1:0] amount;
    logic [2*BREITE-1:0]   dbl_l;
    logic [2*BREITE-1:0]   dbl_r;
    logic [BREITE-1:0]     rot_in;
    logic [LOG2BREITE-1:0] left_idx;
    logic [LOG2BREITE-1:0] right_idx;
    logic                  carry_in;

    assign is_pass  = (Operation > OP_SRA);
    assign is_right = (Operation == OP_ROR) || (Operation == OP_SRL) || (Operation == OP_SRA);
    // Pass-through ops rotate by zero, so stage 2 leaves the operand untouched
    assign amount   = is_pass ? '0 : Stellen;

    assign dbl_l  = {Zahl, Zahl} << amount;
    assign dbl_r  = {Zahl, Zahl} >> amount;
    assign rot_in = is_right ? dbl_r[BREITE-1:0] : dbl_l[2*BREITE-1:BREITE];

    // BREITE is a power of two, so BREITE - amount wraps to the correct index
    assign left_idx  = LOG2BREITE'(BREITE - int'(amount));
    assign right_idx = amount - LOG2BREITE'(1);

    always_comb begin
        carry_in = 1'b0;
        if (amount != '0) begin
            carry_in = is_right ? Zahl[right_idx] : Zahl[left_idx];
        end
    end

    // Stage 2 combinational: masking and sign fill
    logic [BREITE-1:0] ones;
    logic [BREITE-1:0] keep_l;
    logic [BREITE-1:0] keep_r;
    logic [BREITE-1:0] final_val;

    assign ones   = '1;
    assign keep_l = ones << amt1;
    assign keep_r = ones >> amt1;

    always_comb begin
        final_val = rot1;
        case (op1)
            OP_SLL:  final_val = rot1 & keep_l;
            OP_SRL:  final_val = rot1 & keep_r;
            OP_SRA:  final_val = (rot1 & keep_r) | ({BREITE{sign1}} & ~keep_r);
            default: final_val = rot1;
        endcase
    end

    always_ff @(posedge Takt) begin
        if (Reset) begin
            v1        <= 1'b0;
            rot1      <= '0;
            op1       <= '0;
            amt1      <= '0;
            sign1     <= 1'b0;
            carry1    <= 1'b0;
            v2        <= 1'b0;
            Ergebnis  <= '0;
            Uebertrag <= 1'b0;
            Null      <= 1'b0;
        end else begin
            if (load2) begin
                v2 <= v1;
                if (v1) begin
                    Ergebnis  <= final_val;
                    Uebertrag <= carry1;
                    Null      <= (final_val == '0);
                end
            end
            if (!v1 || adv1) begin
                v1 <= in_fire;
                if (in_fire) begin
                    rot1   <= rot_in;
                    op1    <= Operation;
                    amt1   <= amount;
                    sign1  <= Zahl[BREITE-1];
                    carry1 <= carry_in;
                end
            end
        end
    end

endmodule
